// File: rtl/tcp_encoder_pkg.sv
// Shared definitions for the TCP segment encoder: FSM states, protocol
// constants, the latched request record and one's-complement helpers.
package tcp_encoder_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_HDR1,
    S_HDR2,
    S_HDR3,
    S_HDR4,
    S_HDR5,
    S_OPT,
    S_DATA,
    S_FIN
  } state_e;

  localparam logic [7:0]  TCP_PROTO    = 8'd6;
  localparam logic [7:0]  OPT_KIND_MSS = 8'd2;
  localparam logic [7:0]  OPT_LEN_MSS  = 8'd4;
  localparam logic [7:0]  OPT_KIND_WS  = 8'd3;
  localparam logic [7:0]  OPT_LEN_WS   = 8'd3;
  localparam logic [7:0]  OPT_NOP      = 8'd1;
  localparam int unsigned HDR_WORDS    = 5;

  // Request fields captured on an accepted start.
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [5:0]  flags;
    logic [15:0] window;
    logic [15:0] urg_ptr;
    logic [1:0]  opt_en;
    logic [15:0] mss;
    logic [7:0]  scale_wnd;
    logic [15:0] len_data;
  } req_t;

  // 32-bit one's-complement add with end-around carry.
  function automatic logic [31:0] ocadd32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[31:0] + {31'b0, s[32]};
  endfunction

  // Fold a 32-bit one's-complement sum down to 16 bits.
  function automatic logic [15:0] fold16(input logic [31:0] x);
    logic [16:0] t;
    t = {1'b0, x[31:16]} + {1'b0, x[15:0]};
    return t[15:0] + {15'b0, t[16]};
  endfunction

endpackage

// File: rtl/tcp_payload_buffer.sv
// Simple dual-port payload RAM: one write port, one registered read port.
module tcp_payload_buffer #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port; storage is not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tcp_encoder.sv
// TCP segment encoder: latches a request, buffers and sums the payload,
// computes the checksum, then streams header, options and payload words.
module tcp_encoder
  import tcp_encoder_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 1460,
  parameter int unsigned BUF_AW    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dest_port,
  input  logic [31:0] seq_num,
  input  logic [31:0] ack_num,
  input  logic [5:0]  flags,
  input  logic [15:0] window,
  input  logic [15:0] urg_ptr,
  input  logic [1:0]  opt_en,
  input  logic [15:0] mss,
  input  logic [7:0]  scale_wnd,
  input  logic [15:0] len_data,
  input  logic [31:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [31:0] data,
  output logic        wr_en,
  output logic [15:0] len_tcp,
  output logic        busy,
  output logic        fin,
  output logic        err
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [15:0] len_tcp_q, len_tcp_d;
  logic [15:0] nwords_q, nwords_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] pay_sum_q, pay_sum_d;
  logic [15:0] cks_q, cks_d;
  logic        err_q, err_d;

  logic [1:0]  in_nopt, nopt;
  logic [16:0] len_p3;
  logic [3:0]  doff;
  logic [31:0] hdr4_w, mss_w, ws_w, sum_all;
  logic [31:0] pl_mask, pl_masked;
  logic        buf_we;
  logic [BUF_AW-1:0] buf_raddr;
  logic [31:0] buf_rdata;

  assign in_nopt = {1'b0, opt_en[0]} + {1'b0, opt_en[1]};
  assign len_p3  = {1'b0, len_data} + 17'd3;
  assign nopt    = {1'b0, req_q.opt_en[0]} + {1'b0, req_q.opt_en[1]};
  assign doff    = 4'(HDR_WORDS) + {2'b0, nopt};
  assign hdr4_w  = {doff, 6'b0, req_q.flags, req_q.window};
  assign mss_w   = {OPT_KIND_MSS, OPT_LEN_MSS, req_q.mss};
  assign ws_w    = {OPT_NOP, OPT_KIND_WS, OPT_LEN_WS, req_q.scale_wnd};

  // Zero the bytes beyond len_data in the final payload word.
  always_comb begin
    pl_mask = '1;
    if (cnt_q == nwords_q - 16'd1) begin
      case (req_q.len_data[1:0])
        2'd1:    pl_mask = 32'hFF00_0000;
        2'd2:    pl_mask = 32'hFFFF_0000;
        2'd3:    pl_mask = 32'hFFFF_FF00;
        default: pl_mask = '1;
      endcase
    end
    pl_masked = pl_data & pl_mask;
  end

  // Full checksum sum: pseudo-header, header (checksum zero), options, payload.
  always_comb begin
    sum_all = ocadd32(req_q.src_ip, req_q.dest_ip);
    sum_all = ocadd32(sum_all, {8'h00, TCP_PROTO, len_tcp_q});
    sum_all = ocadd32(sum_all, {req_q.src_port, req_q.dest_port});
    sum_all = ocadd32(sum_all, req_q.seq_num);
    sum_all = ocadd32(sum_all, req_q.ack_num);
    sum_all = ocadd32(sum_all, hdr4_w);
    sum_all = ocadd32(sum_all, {16'h0000, req_q.urg_ptr});
    if (req_q.opt_en[0]) sum_all = ocadd32(sum_all, mss_w);
    if (req_q.opt_en[1]) sum_all = ocadd32(sum_all, ws_w);
    sum_all = ocadd32(sum_all, pay_sum_q);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    len_tcp_d = len_tcp_q;
    nwords_d  = nwords_q;
    cnt_d     = cnt_q;
    pay_sum_d = pay_sum_q;
    cks_d     = cks_q;
    err_d     = 1'b0;
    buf_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_data > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            req_d     = '{src_ip: src_ip, dest_ip: dest_ip, src_port: src_port,
                          dest_port: dest_port, seq_num: seq_num, ack_num: ack_num,
                          flags: flags, window: window, urg_ptr: urg_ptr,
                          opt_en: opt_en, mss: mss, scale_wnd: scale_wnd,
                          len_data: len_data};
            len_tcp_d = 16'd20 + {12'b0, in_nopt, 2'b00} + len_data;
            nwords_d  = {1'b0, len_p3[16:2]};
            cnt_d     = '0;
            pay_sum_d = '0;
            state_d   = (len_data != 16'd0) ? S_LOAD : S_CALC;
          end
        end
      end
      S_LOAD: begin
        if (pl_valid) begin
          buf_we    = 1'b1;
          pay_sum_d = ocadd32(pay_sum_q, pl_masked);
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == nwords_q - 16'd1) begin
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cks_d   = ~fold16(sum_all);
        state_d = S_HDR1;
      end
      S_HDR1: state_d = S_HDR2;
      S_HDR2: state_d = S_HDR3;
      S_HDR3: state_d = S_HDR4;
      S_HDR4: state_d = S_HDR5;
      S_HDR5: begin
        cnt_d = '0;
        if (nopt != 2'd0)           state_d = S_OPT;
        else if (nwords_q != 16'd0) state_d = S_DATA;
        else                        state_d = S_FIN;
      end
      S_OPT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == {14'b0, nopt} - 16'd1) begin
          cnt_d   = '0;
          state_d = (nwords_q != 16'd0) ? S_DATA : S_FIN;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == nwords_q - 16'd1) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      len_tcp_q <= '0;
      nwords_q  <= '0;
      cnt_q     <= '0;
      pay_sum_q <= '0;
      cks_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      len_tcp_q <= len_tcp_d;
      nwords_q  <= nwords_d;
      cnt_q     <= cnt_d;
      pay_sum_q <= pay_sum_d;
      cks_q     <= cks_d;
      err_q     <= err_d;
    end
  end

  // Read one word ahead so the registered RAM output lines up with DATA.
  assign buf_raddr = (state_q == S_DATA) ? cnt_q[BUF_AW-1:0] + BUF_AW'(1) : '0;

  tcp_payload_buffer #(
    .AW (BUF_AW),
    .DW (32)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q[BUF_AW-1:0]),
    .wdata (pl_masked),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Output word mux decoded from the current state.
  always_comb begin
    data  = '0;
    wr_en = 1'b0;
    fin   = 1'b0;
    case (state_q)
      S_HDR1: begin data = {req_q.src_port, req_q.dest_port}; wr_en = 1'b1; end
      S_HDR2: begin data = req_q.seq_num;                     wr_en = 1'b1; end
      S_HDR3: begin data = req_q.ack_num;                     wr_en = 1'b1; end
      S_HDR4: begin data = hdr4_w;                            wr_en = 1'b1; end
      S_HDR5: begin data = {cks_q, req_q.urg_ptr};            wr_en = 1'b1; end
      S_OPT: begin
        data  = (req_q.opt_en[0] && cnt_q == 16'd0) ? mss_w : ws_w;
        wr_en = 1'b1;
      end
      S_DATA: begin data = buf_rdata; wr_en = 1'b1; end
      S_FIN:  fin = 1'b1;
      default: ;
    endcase
  end

  assign pl_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign len_tcp  = len_tcp_q;

endmodule

// File: tb/tb_tcp_encoder.sv
// Directed bench for tcp_encoder: table of segments plus reject, stall and
// mid-segment reset sequences.
module tb_tcp_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_ip, dest_ip, seq_num, ack_num, pl_data;
  logic [15:0] src_port, dest_port, window, urg_ptr, mss, len_data;
  logic [5:0]  flags;
  logic [1:0]  opt_en;
  logic [7:0]  scale_wnd;
  logic        pl_valid;
  logic        pl_ready, wr_en, busy, fin, err;
  logic [31:0] data;
  logic [15:0] len_tcp;

  always #5 clk = ~clk;

  tcp_encoder #(.MAX_BYTES(1460), .BUF_AW(9)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_ip(src_ip), .dest_ip(dest_ip), .src_port(src_port), .dest_port(dest_port),
    .seq_num(seq_num), .ack_num(ack_num), .flags(flags), .window(window),
    .urg_ptr(urg_ptr), .opt_en(opt_en), .mss(mss), .scale_wnd(scale_wnd),
    .len_data(len_data), .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .data(data), .wr_en(wr_en), .len_tcp(len_tcp), .busy(busy), .fin(fin), .err(err)
  );

  typedef struct packed {
    logic [31:0]       sip, dip;
    logic [15:0]       sp, dp;
    logic [31:0]       seq, ack;
    logic [5:0]        flg;
    logic [15:0]       win, urg;
    logic [1:0]        opt;
    logic [15:0]       mss;
    logic [7:0]        scl;
    logic [15:0]       len;
    logic [3:0][31:0]  pl;
    logic [15:0]       e_len_tcp;
    logic [15:0]       e_words;
    logic [3:0]        e_doff;
    logic [31:0]       e_w5;
    logic [31:0]       e_last;
  } vec_t;

  vec_t vec [5];

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned cyc = 0, fin_cnt = 0, err_cnt = 0, busy_cnt = 0;
  logic [31:0] cap_w [$];
  int unsigned cap_c [$];
  logic [31:0] exp_q [$];

  // Passive monitor sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      cap_w.push_back(data);
      cap_c.push_back(cyc);
    end
    if (fin)  fin_cnt++;
    if (err)  err_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pword(input vec_t v, input int unsigned i);
    logic [31:0] ii;
    ii = i;
    if (v.len > 16'd16) return {ii[15:0], ~ii[15:0]};
    return v.pl[ii[1:0]];
  endfunction

  function automatic logic [7:0] pbyte(input vec_t v, input int unsigned k);
    logic [31:0] w;
    w = pword(v, k / 4);
    case (k % 4)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic int unsigned add_w(input int unsigned s, input logic [31:0] w);
    return s + {16'h0, w[31:16]} + {16'h0, w[15:0]};
  endfunction

  // Reference segment: 16-bit one's-complement checksum over a byte stream.
  task automatic build_exp(input vec_t v);
    int unsigned s, nopt, nw;
    logic [31:0] h4, mssw, wsw, w;
    logic [15:0] cks;
    logic [3:0]  doff;
    exp_q.delete();
    nopt = 32'(v.opt[0]) + 32'(v.opt[1]);
    doff = 4'(5 + nopt);
    h4   = {doff, 6'b0, v.flg, v.win};
    mssw = {8'h02, 8'h04, v.mss};
    wsw  = {8'h01, 8'h03, 8'h03, v.scl};
    s = 0;
    s = add_w(s, v.sip);
    s = add_w(s, v.dip);
    s = add_w(s, {16'h0006, v.e_len_tcp});
    s = add_w(s, {v.sp, v.dp});
    s = add_w(s, v.seq);
    s = add_w(s, v.ack);
    s = add_w(s, h4);
    s = add_w(s, {16'h0, v.urg});
    if (v.opt[0]) s = add_w(s, mssw);
    if (v.opt[1]) s = add_w(s, wsw);
    for (int unsigned k = 0; k < 32'(v.len); k += 2)
      s = s + {16'h0, pbyte(v, k), (k + 1 < 32'(v.len)) ? pbyte(v, k + 1) : 8'h00};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    cks = ~s[15:0];
    exp_q.push_back({v.sp, v.dp});
    exp_q.push_back(v.seq);
    exp_q.push_back(v.ack);
    exp_q.push_back(h4);
    exp_q.push_back({cks, v.urg});
    if (v.opt[0]) exp_q.push_back(mssw);
    if (v.opt[1]) exp_q.push_back(wsw);
    nw = (32'(v.len) + 3) / 4;
    for (int unsigned i = 0; i < nw; i++) begin
      w = '0;
      for (int unsigned b = 0; b < 4; b++)
        if (4 * i + b < 32'(v.len)) w = w | ({24'h0, pbyte(v, 4 * i + b)} << (8 * (3 - b)));
      exp_q.push_back(w);
    end
  endtask

  task automatic drive_start(input vec_t v, output int unsigned last_cyc);
    @(negedge clk);
    src_ip = v.sip; dest_ip = v.dip; src_port = v.sp; dest_port = v.dp;
    seq_num = v.seq; ack_num = v.ack; flags = v.flg; window = v.win;
    urg_ptr = v.urg; opt_en = v.opt; mss = v.mss; scale_wnd = v.scl;
    len_data = v.len;
    start = 1'b1;
    @(posedge clk);
    last_cyc = cyc;
    #1 start = 1'b0;
  endtask

  // Feed payload; optional 3-cycle stall after stall_at words with a stray start.
  task automatic feed(input vec_t v, input int stall_at, input bit extra_start,
                      inout int unsigned last_cyc);
    int unsigned w, acc, budget, stalls;
    bit rdy;
    w = (32'(v.len) + 3) / 4;
    acc = 0; budget = 0; stalls = 0;
    while (acc < w && budget < 5000) begin
      @(negedge clk);
      budget++;
      if (stall_at >= 0 && acc == 32'(stall_at) && stalls < 3) begin
        pl_valid = 1'b0;
        pl_data  = 32'hBAD0_BAD0;
        if (extra_start && stalls == 0) start = 1'b1;
        stalls++;
      end else begin
        pl_valid = 1'b1;
        pl_data  = pword(v, acc);
      end
      rdy = pl_ready && pl_valid;
      @(posedge clk);
      if (rdy) begin
        acc++;
        last_cyc = cyc;
      end
      #1 start = 1'b0;
    end
    pl_valid = 1'b0;
    if (acc < w) chk("load_timeout", acc, w);
  endtask

  task automatic run_seg(input string tag, input int idx, input int stall_at, input bit extra_start);
    vec_t v;
    int unsigned base, fin0, err0, lc, budget, n, s;
    v = vec[idx];
    build_exp(v);
    base = cap_w.size(); fin0 = fin_cnt; err0 = err_cnt;
    drive_start(v, lc);
    feed(v, stall_at, extra_start, lc);
    budget = 0;
    while (fin_cnt == fin0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    repeat (4) @(posedge clk);
    n = cap_w.size() - base;
    chk({tag, ".len_tcp"}, {16'h0, len_tcp}, {16'h0, v.e_len_tcp});
    chk({tag, ".nwords"}, n, {16'h0, v.e_words});
    chk({tag, ".fin"}, fin_cnt - fin0, 1);
    chk({tag, ".err"}, err_cnt - err0, 0);
    chk({tag, ".busy_after"}, {31'h0, busy}, 0);
    if (n > 5) begin
      chk({tag, ".latency"}, cap_c[base] - lc, 2);
      chk({tag, ".contig"}, cap_c[base + n - 1] - cap_c[base] + 1, n);
      chk({tag, ".doff"}, {28'h0, cap_w[base + 3][31:28]}, {28'h0, v.e_doff});
      chk({tag, ".w5"}, cap_w[base + 5], v.e_w5);
      chk({tag, ".last"}, cap_w[base + n - 1], v.e_last);
    end
    for (int unsigned i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s.word%0d", tag, i), cap_w[base + i], exp_q[i]);
    // Receiver-side verification: the whole segment plus pseudo-header sums to 0xFFFF.
    s = 0;
    s = add_w(s, v.sip);
    s = add_w(s, v.dip);
    s = add_w(s, {16'h0006, v.e_len_tcp});
    for (int unsigned i = 0; i < n; i++) s = add_w(s, cap_w[base + i]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    chk({tag, ".rx_cks"}, s, 32'hFFFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, err0, busy0, fin0, lc, budget;
    vec_t rv;

    vec[0] = '{default: '0, sip: 32'hC0A8_0001, dip: 32'hC0A8_0002, sp: 16'h1F90, dp: 16'h0050,
               seq: 32'h1234_5678, flg: 6'b000010, win: 16'hFFFF, opt: 2'b11, mss: 16'd1460,
               scl: 8'd7, len: 16'd0, e_len_tcp: 16'd28, e_words: 16'd7, e_doff: 4'd7,
               e_w5: 32'h0204_05B4, e_last: 32'h0103_0307};
    vec[1] = '{default: '0, sip: 32'h0A00_0001, dip: 32'h0A00_0002, sp: 16'hC350, dp: 16'h0050,
               seq: 32'h0000_1000, ack: 32'h0000_2000, flg: 6'b010000, win: 16'h0400,
               opt: 2'b00, len: 16'd5, e_len_tcp: 16'd25, e_words: 16'd7, e_doff: 4'd5,
               e_w5: 32'h4142_4344, e_last: 32'h4500_0000};
    vec[1].pl[0] = 32'h4142_4344;
    vec[1].pl[1] = 32'h45AA_BBCC;
    vec[2] = '{default: '0, sip: 32'hAC10_0A01, dip: 32'h0808_0808, sp: 16'h8001, dp: 16'h01BB,
               seq: 32'hFFFF_FFF0, ack: 32'h8000_0001, flg: 6'b011000, win: 16'h2000,
               urg: 16'h0001, opt: 2'b10, scl: 8'd14, len: 16'd8, e_len_tcp: 16'd32,
               e_words: 16'd8, e_doff: 4'd6, e_w5: 32'h0103_030E, e_last: 32'h0405_0607};
    vec[2].pl[0] = 32'h0001_0203;
    vec[2].pl[1] = 32'h0405_0607;
    vec[3] = '{default: '0, sip: 32'hFFFF_FFFF, dip: 32'hFFFF_0000, sp: 16'hFFFF, dp: 16'h0001,
               seq: 32'hDEAD_0000, ack: 32'h0000_BEEF, flg: 6'b110001, win: 16'h0001,
               urg: 16'h0003, opt: 2'b01, mss: 16'h0218, len: 16'd3, e_len_tcp: 16'd27,
               e_words: 16'd7, e_doff: 4'd6, e_w5: 32'h0204_0218, e_last: 32'hDEAD_BE00};
    vec[3].pl[0] = 32'hDEAD_BEEF;
    vec[4] = '{default: '0, sip: 32'h0102_0304, dip: 32'h0506_0708, sp: 16'h0400, dp: 16'h0401,
               seq: 32'h0000_0001, ack: 32'h0000_0002, flg: 6'b011000, win: 16'h7FFF,
               opt: 2'b00, len: 16'd1460, e_len_tcp: 16'd1480, e_words: 16'd370, e_doff: 4'd5,
               e_w5: 32'h0000_FFFF, e_last: 32'h016C_FE93};

    start = 1'b0; pl_valid = 1'b0; pl_data = '0;
    src_ip = '0; dest_ip = '0; src_port = '0; dest_port = '0; seq_num = '0; ack_num = '0;
    flags = '0; window = '0; urg_ptr = '0; opt_en = '0; mss = '0; scale_wnd = '0; len_data = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #3;
    chk("reset.data", data, 0);
    chk("reset.flags", {26'h0, wr_en, busy, fin, err, pl_ready, 1'b0}, 0);
    chk("reset.len_tcp", {16'h0, len_tcp}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) run_seg($sformatf("vec%0d", i), i, -1, 1'b0);

    // Oversize request is rejected with a single err pulse and no output.
    base = cap_w.size(); err0 = err_cnt; busy0 = busy_cnt; fin0 = fin_cnt;
    rv = vec[1];
    rv.len = 16'd1461;
    drive_start(rv, lc);
    repeat (6) @(posedge clk);
    chk("reject.err", err_cnt - err0, 1);
    chk("reject.busy", busy_cnt - busy0, 0);
    chk("reject.wr", cap_w.size() - base, 0);
    chk("reject.fin", fin_cnt - fin0, 0);

    // Stalled payload with a stray start while busy.
    run_seg("stall", 1, 1, 1'b1);
    base = cap_w.size();
    repeat (8) @(posedge clk);
    chk("stall.no_extra", cap_w.size() - base, 0);

    // Reset during DATA, then a clean segment.
    base = cap_w.size(); fin0 = fin_cnt;
    drive_start(vec[4], lc);
    feed(vec[4], -1, 1'b0, lc);
    budget = 0;
    while (cap_w.size() - base < 20 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    chk("midrst.reached_data", {31'h0, (cap_w.size() - base >= 20)}, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst.data", data, 0);
    chk("midrst.flags", {26'h0, wr_en, busy, fin, err, pl_ready, 1'b0}, 0);
    chk("midrst.len_tcp", {16'h0, len_tcp}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    chk("midrst.no_fin", fin_cnt - fin0, 0);
    run_seg("after_rst", 1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
